// File: rtl/beam_scan_sequencer.sv
// -----------------------------------------------------------------------------
// beam_scan_sequencer
//
// Steps a speaker array through a sequence of beams. For every beam it writes
// one phase-shift register per speaker (phase of speaker k = k*step mod 16),
// holds the beam for a programmable dwell time, then advances the inter-speaker
// phase step by step_delta and loads the next beam. After the last beam it
// emits a single-cycle scan_done pulse and returns to idle.
//
// Ports
//   clk           640 kHz clock, all logic on the rising edge
//   rst           asynchronous, active-high reset
//   start         single-cycle pulse, begins a scan when idle
//   stop          level, aborts any scan and forces idle (wins over start)
//   step_init     phase increment between adjacent speakers for beam 0
//   step_delta    added (mod 16) to the increment after each beam
//   num_beams_m1  number of beams in the scan minus one
//   dwell         cycles each beam is held after loading (0 behaves as 1)
//   wr_en         register-file write strobe, high only while loading
//   wr_addr       register address of the write (holds when wr_en is low)
//   wr_data       phase value of the write (holds when wr_en is low)
//   busy          high whenever the sequencer is not idle
//   beam_index    index of the beam currently loaded or dwelling
//   scan_done     single-cycle pulse at scan completion
// -----------------------------------------------------------------------------
module beam_scan_sequencer #(
   parameter int          NUM_SPEAKERS = 37,
   parameter logic [5:0]  BASE_ADDR    = 6'h10,
   parameter int          DWELL_W      = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [3:0]         step_init,
   input  logic [3:0]         step_delta,
   input  logic [3:0]         num_beams_m1,
   input  logic [DWELL_W-1:0] dwell,
   output logic               wr_en,
   output logic [5:0]         wr_addr,
   output logic [3:0]         wr_data,
   output logic               busy,
   output logic [3:0]         beam_index,
   output logic               scan_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DWELL,
      S_NEXT,
      S_DONE
   } state_t;

   localparam logic [5:0] LAST_K = 6'(NUM_SPEAKERS - 1);

   state_t             r_state;
   logic [3:0]         r_step;        // current inter-speaker phase increment
   logic [3:0]         r_delta;       // latched step_delta
   logic [3:0]         r_nbm1;        // latched num_beams_m1
   logic [DWELL_W-1:0] r_dwell;       // latched dwell
   logic [DWELL_W-1:0] r_dwell_cnt;
   logic [5:0]         r_k;           // speaker currently presented on the write port
   logic [3:0]         r_acc;         // phase currently presented on the write port
   logic [3:0]         r_beam;
   logic               r_wr_en;
   logic [5:0]         r_wr_addr;
   logic [3:0]         r_wr_data;
   logic               r_busy;
   logic               r_scan_done;

   logic [3:0]         w_next_acc;
   logic [5:0]         w_next_k;
   logic [DWELL_W-1:0] w_dwell_load;
   logic               w_last_beam;

   assign w_next_acc   = r_acc + r_step;
   assign w_next_k     = r_k + 6'd1;
   assign w_dwell_load = (r_dwell == '0) ? DWELL_W'(1) : r_dwell;
   assign w_last_beam  = (r_beam == r_nbm1);

   // The write port registers are loaded one cycle ahead (on the edge that
   // enters or stays in LOAD) so that wr_en is high exactly during the LOAD
   // cycles while every output still comes straight from a flop.
   // NOTE: all state here is updated with non-blocking assignments so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_step      <= '0;
         r_delta     <= '0;
         r_nbm1      <= '0;
         r_dwell     <= '0;
         r_dwell_cnt <= '0;
         r_k         <= '0;
         r_acc       <= '0;
         r_beam      <= '0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_busy      <= 1'b0;
         r_scan_done <= 1'b0;
      end else if (stop) begin
         // Abort: partially written beam, beam index and write port are kept.
         r_state     <= S_IDLE;
         r_wr_en     <= 1'b0;
         r_busy      <= 1'b0;
         r_scan_done <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_scan_done <= 1'b0;
               if (start) begin
                  r_step    <= step_init;
                  r_delta   <= step_delta;
                  r_nbm1    <= num_beams_m1;
                  r_dwell   <= dwell;
                  r_beam    <= '0;
                  r_k       <= '0;
                  r_acc     <= '0;
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= BASE_ADDR;
                  r_wr_data <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (r_k == LAST_K) begin
                  r_wr_en     <= 1'b0;
                  r_dwell_cnt <= w_dwell_load;
                  r_state     <= S_DWELL;
               end else begin
                  r_k       <= w_next_k;
                  r_acc     <= w_next_acc;
                  r_wr_addr <= BASE_ADDR + w_next_k;
                  r_wr_data <= w_next_acc;
               end
            end
            S_DWELL: begin
               if (r_dwell_cnt <= DWELL_W'(1)) begin
                  r_state <= S_NEXT;
               end else begin
                  r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
               end
            end
            S_NEXT: begin
               if (w_last_beam) begin
                  r_scan_done <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_beam    <= r_beam + 4'd1;
                  r_step    <= r_step + r_delta;
                  r_k       <= '0;
                  r_acc     <= '0;
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= BASE_ADDR;
                  r_wr_data <= '0;
                  r_state   <= S_LOAD;
               end
            end
            S_DONE: begin
               r_scan_done <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: begin
               r_wr_en     <= 1'b0;
               r_busy      <= 1'b0;
               r_scan_done <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign wr_en      = r_wr_en;
   assign wr_addr    = r_wr_addr;
   assign wr_data    = r_wr_data;
   assign busy       = r_busy;
   assign beam_index = r_beam;
   assign scan_done  = r_scan_done;

endmodule

// File: tb/tb_beam_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_beam_scan_sequencer
//
// Scoreboard bench for beam_scan_sequencer. Stimulus pushes the expected
// register writes (address, phase, beam index) and the expected scan_done
// cycle into queues; a monitor on the falling edge pops and compares whenever
// the DUT strobes wr_en or scan_done. Directed checks cover reset values,
// stop, ignored start, start+stop together and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_beam_scan_sequencer;

   localparam int N = 37;

   typedef struct {
      logic [5:0] addr;
      logic [3:0] data;
      logic [3:0] beam;
   } wr_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic        stop;
   logic [3:0]  step_init;
   logic [3:0]  step_delta;
   logic [3:0]  num_beams_m1;
   logic [15:0] dwell;
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic [3:0]  wr_data;
   logic        busy;
   logic [3:0]  beam_index;
   logic        scan_done;

   wr_t wr_q[$];
   int  done_q[$];
   int  cyc;
   int  n_cmp;
   int  n_fail;

   beam_scan_sequencer #(
      .NUM_SPEAKERS(N),
      .BASE_ADDR   (6'h10),
      .DWELL_W     (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .step_init   (step_init),
      .step_delta  (step_delta),
      .num_beams_m1(num_beams_m1),
      .dwell       (dwell),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .busy        (busy),
      .beam_index  (beam_index),
      .scan_done   (scan_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares every write and every scan_done pulse to the queues.
   always @(negedge clk) begin
      if (!rst) begin
         if (wr_en) begin
            if (wr_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_write: addr 0x%0h data %0d, expected no write (cycle %0d)",
                        wr_addr, wr_data, cyc);
            end else begin
               wr_t e;
               e = wr_q.pop_front();
               check("wr_addr", 32'(wr_addr), 32'(e.addr));
               check("wr_data", 32'(wr_data), 32'(e.data));
               check("wr_beam_index", 32'(beam_index), 32'(e.beam));
               check("busy_during_load", 32'(busy), 32'd1);
            end
         end
         if (scan_done) begin
            if (done_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_scan_done: got pulse, expected none (cycle %0d)", cyc);
            end else begin
               int e_cyc;
               e_cyc = done_q.pop_front();
               check("scan_done_cycle", 32'(cyc), 32'(e_cyc));
            end
         end
      end
   end

   // Expected writes for a scan, optionally truncated after max_wr writes.
   task automatic push_writes(input logic [3:0] si, input logic [3:0] sd,
                              input int nbm1, input int max_wr);
      int n;
      n = 0;
      for (int b = 0; b <= nbm1; b++) begin
         int s;
         s = (int'(si) + b * int'(sd)) % 16;
         for (int k = 0; k < N; k++) begin
            wr_t e;
            if (n < max_wr) begin
               e.addr = 6'(16 + k);
               e.data = 4'((k * s) % 16);
               e.beam = 4'(b);
               wr_q.push_back(e);
            end
            n++;
         end
      end
   endtask

   // Drives the scan inputs and a one-cycle start; returns the cycle count of
   // the edge that sampled start (the first LOAD cycle carries that count).
   task automatic pulse_start(input logic [3:0] si, input logic [3:0] sd,
                              input logic [3:0] nbm1, input logic [15:0] dw,
                              output int c);
      step_init    = si;
      step_delta   = sd;
      num_beams_m1 = nbm1;
      dwell        = dw;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      c = cyc;
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_scan(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done_q.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s_timeout: scan still busy, expected completion within 3000 cycles", name);
      end
      check({name, "_writes_drained"}, 32'(wr_q.size()), 32'd0);
   endtask

   task automatic do_reset_pulse();
      rst = 1'b1;
      #1;
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_beam_index", 32'(beam_index), 32'd0);
      check("rst_scan_done", 32'(scan_done), 32'd0);
      wr_q.delete();
      done_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      int c;
      n_cmp        = 0;
      n_fail       = 0;
      rst          = 1'b0;
      start        = 1'b0;
      stop         = 1'b0;
      step_init    = '0;
      step_delta   = '0;
      num_beams_m1 = '0;
      dwell        = '0;
      #1;
      do_reset_pulse();
      repeat (2) @(posedge clk);
      #1;

      // One beam, step 3, dwell 5: DONE shows 37+5+1 cycles after the first LOAD cycle.
      push_writes(4'd3, 4'd0, 0, 1000);
      pulse_start(4'd3, 4'd0, 4'd0, 16'd5, c);
      done_q.push_back(c + 43);
      wait_scan("single_beam");
      check("hold_wr_addr", 32'(wr_addr), 32'h34);
      check("hold_wr_data", 32'(wr_data), 32'd12);
      check("hold_wr_en", 32'(wr_en), 32'd0);

      // Three beams, steps 1,3,5, dwell 0 behaves as 1.
      push_writes(4'd1, 4'd2, 2, 1000);
      pulse_start(4'd1, 4'd2, 4'd2, 16'd0, c);
      done_q.push_back(c + 3 * (N + 1 + 1));
      wait_scan("three_beams");
      check("last_beam_index", 32'(beam_index), 32'd2);
      check("last_wr_data", 32'(wr_data), 32'd4);

      // Stop during the 10th LOAD cycle: that write still happens, nothing after.
      push_writes(4'd3, 4'd0, 0, 10);
      pulse_start(4'd3, 4'd0, 4'd0, 16'd5, c);
      wait_cyc(c + 9);
      stop = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("stop_wr_en", 32'(wr_en), 32'd0);
      check("stop_busy", 32'(busy), 32'd0);
      check("stop_beam_index", 32'(beam_index), 32'd0);
      check("stop_writes_drained", 32'(wr_q.size()), 32'd0);
      @(posedge clk);
      #1 stop = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // start during DWELL with different inputs is ignored.
      push_writes(4'd2, 4'd1, 1, 1000);
      pulse_start(4'd2, 4'd1, 4'd1, 16'd4, c);
      done_q.push_back(c + 2 * (N + 4 + 1));
      wait_cyc(c + 38);
      step_init    = 4'd7;
      step_delta   = 4'd9;
      num_beams_m1 = 4'd5;
      dwell        = 16'd1;
      start        = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_scan("ignored_start");

      // start and stop together while idle: no scan.
      stop  = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("start_stop_busy", 32'(busy), 32'd0);
      end
      @(posedge clk);
      #1 stop = 1'b0;

      // Reset mid-LOAD of beam 0.
      push_writes(4'd5, 4'd3, 2, 1000);
      pulse_start(4'd5, 4'd3, 4'd2, 16'd6, c);
      wait_cyc(c + 5);
      check("pre_rst_load_wr_en", 32'(wr_en), 32'd1);
      do_reset_pulse();

      // Reset mid-DWELL of beam 1 (beam 1 DWELL spans c+81 .. c+86).
      push_writes(4'd5, 4'd3, 2, 1000);
      pulse_start(4'd5, 4'd3, 4'd2, 16'd6, c);
      wait_cyc(c + 83);
      check("pre_rst_beam_index", 32'(beam_index), 32'd1);
      check("pre_rst_busy", 32'(busy), 32'd1);
      do_reset_pulse();
      repeat (2) @(posedge clk);
      #1;

      // Complete scan after reset starts again from beam 0.
      push_writes(4'd4, 4'd1, 1, 1000);
      pulse_start(4'd4, 4'd1, 4'd1, 16'd2, c);
      done_q.push_back(c + 2 * (N + 2 + 1));
      wait_scan("after_reset");
      check("after_reset_beam_index", 32'(beam_index), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
